// File: rtl/data_mem_responder.sv
// Data-port memory responder: a word-organised RAM with byte-lane stores behind
// a req/ready request handshake and a one-cycle resp_valid completion pulse.
// Each request passes through IDLE -> [WAIT] -> ACCESS -> RESP. A rejected
// request goes straight from IDLE to RESP and never touches the array.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         lane_q, lane_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic               below_base;
    logic [31:0]        req_off;
    logic [31:0]        req_word;
    logic               req_err;
    logic [31:0]        mem_rword;
    logic [31:0]        rword_shifted;
    logic [31:0]        load_data;
    logic [31:0]        store_data;
    logic [3:0]         store_be;
    logic               mem_we;

    logic [31:0]        mem [DEPTH_WORDS];

    // Decode the incoming request: word offset from the base and legality.
    always_comb begin
        // The borrow out of a 33-bit subtract flags addresses below the base.
        {below_base, req_off} = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        req_word = req_off >> 2;
        req_err  = (req_size == SZ_BAD)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || below_base
                || (req_word >= DEPTH_W);
    end

    // Array datapath from captured request fields only, so load data and store
    // lanes do not depend on the request inputs after acceptance.
    always_comb begin
        mem_rword     = mem[idx_q];
        rword_shifted = mem_rword >> {lane_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_data = {24'h0, rword_shifted[7:0]};
            SZ_HALF: load_data = {16'h0, rword_shifted[15:0]};
            default: load_data = rword_shifted;
        endcase
        store_data = wdata_q << {lane_q, 3'b000};
        case (size_q)
            SZ_BYTE: store_be = 4'b0001 << lane_q;
            SZ_HALF: store_be = 4'b0011 << lane_q;
            default: store_be = 4'b1111;
        endcase
        mem_we = (state_q == ST_ACCESS) && write_q;
    end

    // Next-state and capture logic of the request FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned; an unassigned path in always_comb would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        size_d       = size_q;
        lane_d       = lane_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    lane_d  = req_addr[1:0];
                    idx_d   = req_word[IDX_W-1:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (WAIT_CYCLES != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_d      = ST_RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = write_q ? 32'h0 : load_data;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and capture registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            idx_q        <= '0;
            wdata_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Lane-masked store on the edge that leaves ACCESS. Reset forces the state
    // out of ACCESS asynchronously, which is what suppresses an aborted store.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; only control state needs a known value.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) begin
                    mem[idx_q][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
